// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered, parametrised ALU with a start/busy/done handshake,
//            a persistent NZVC flag register, carry-chained ADC/SBC, 1-bit
//            shifts and a multi-cycle shift-and-add unsigned multiply.
// Ports    : clk      - rising-edge clock
//            rst_n    - asynchronous active-low reset
//            start    - operation request, sampled only while idle
//            A, B     - operands (latched on the accepted start edge)
//            ALU_Sel  - operation select (0..10 defined, 11..15 reserved)
//            Result   - registered result, updated only with done
//            NZVC     - registered flags {N,Z,V,C}, updated only with done
//            busy     - high while a multiply is iterating
//            done     - one-cycle pulse marking a Result/NZVC update
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       NZVC,
  output logic             busy,
  output logic             done
);

  localparam int              MSB      = WIDTH - 1;
  localparam logic [3:0]      OP_MUL   = 4'd10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  // S_EXEC is the single cycle in which a one-cycle op is evaluated from the
  // latched operands; writeback happens on the edge leaving it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic latch_en;
  logic mul_step;
  logic wb_en;

  // Latched operation
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [3:0]         op_sel;
  logic               op_cin;

  // Multiplier datapath
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  // ALU evaluation
  logic [WIDTH:0]     ext_a;
  logic [WIDTH:0]     ext_b;
  logic [WIDTH:0]     ext_c;
  logic [WIDTH:0]     wide;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;
  logic               alu_c;
  logic [3:0]         alu_flags;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    latch_en = 1'b0;
    mul_step = 1'b0;
    wb_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          state_nx = (ALU_Sel == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        wb_en    = 1'b1;
        state_nx = S_DONE;
      end
      S_MUL: begin
        // cnt counts completed iterations; writeback once all WIDTH are in.
        if (cnt == CNT_LAST) begin
          wb_en    = 1'b1;
          state_nx = S_DONE;
        end else begin
          mul_step = 1'b1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= '0;
      op_cin <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      Result <= '0;
      NZVC   <= 4'b0000;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (latch_en) begin
        op_a   <= A;
        op_b   <= B;
        op_sel <= ALU_Sel;
        op_cin <= NZVC[0];
        mcand  <= {{WIDTH{1'b0}}, A};
        mplier <= B;
        acc    <= '0;
        cnt    <= '0;
      end
      if (mul_step) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      busy <= mul_step;
      done <= wb_en;
      if (wb_en) begin
        Result <= alu_res;
        NZVC   <= alu_flags;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result / flag evaluation from the latched operation
  // --------------------------------------------------------------------------
  assign ext_a = {1'b0, op_a};
  assign ext_b = {1'b0, op_b};
  assign ext_c = {{WIDTH{1'b0}}, op_cin};

  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (op_sel)
      4'd0, 4'd1: begin
        wide    = (op_sel == 4'd1) ? (ext_a + ext_b + ext_c) : (ext_a + ext_b);
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      4'd2, 4'd3: begin
        // Bit WIDTH of the extended difference is the borrow.
        wide    = (op_sel == 4'd3) ? (ext_a - ext_b - ext_c) : (ext_a - ext_b);
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      4'd4: alu_res = op_a & op_b;
      4'd5: alu_res = op_a | op_b;
      4'd6: alu_res = op_a ^ op_b;
      4'd7: alu_res = ~op_a;
      4'd8: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[MSB];
      end
      4'd9: begin
        alu_res = {1'b0, op_a[WIDTH-1:1]};
        alu_c   = op_a[0];
      end
      4'd10: begin
        alu_res = acc[WIDTH-1:0];
        alu_c   = |acc[2*WIDTH-1:WIDTH];
        alu_v   = alu_c;
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  assign alu_flags = {alu_res[MSB], (alu_res == '0), alu_v, alu_c};

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=8): directed steps plus
//            randomized operations against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALU_Sel;
  logic [W-1:0] Result;
  logic [3:0]   NZVC;
  logic         busy;
  logic         done;

  int total;
  int bad;

  logic         flag_c;
  logic [W-1:0] prev_res;
  logic [3:0]   prev_flags;

  alu_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .ALU_Sel (ALU_Sel),
    .Result  (Result),
    .NZVC    (NZVC),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: signed/unsigned integer arithmetic on the operand values.
  function automatic logic [W+3:0] model(input int sel, input int a, input int b, input int cin);
    int     m, h, sa, sb, s, r, c, v;
    longint p;
    logic [W-1:0] rr;
    logic nf, zf, vf, cf;
    m  = 1 << W;
    h  = m / 2;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    r = 0; c = 0; v = 0;
    case (sel)
      0: begin s = a + b;         r = s % m; c = int'(s >= m);
               s = sa + sb;       v = int'(s < -h || s >= h); end
      1: begin s = a + b + cin;   r = s % m; c = int'(s >= m);
               s = sa + sb + cin; v = int'(s < -h || s >= h); end
      2: begin r = (a - b + m) % m;           c = int'(a < b);
               s = sa - sb;       v = int'(s < -h || s >= h); end
      3: begin r = (a - b - cin + 2*m) % m;   c = int'(a < b + cin);
               s = sa - sb - cin; v = int'(s < -h || s >= h); end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = m - 1 - a;
      8: begin r = (a * 2) % m; c = int'(a >= h); end
      9: begin r = a / 2;       c = a % 2; end
      10: begin
        p = longint'(a) * longint'(b);
        r = int'(p % longint'(m));
        c = int'(p >= longint'(m));
        v = c;
      end
      default: r = 0;
    endcase
    rr = W'(r);
    nf = (r >= h);
    zf = (r == 0);
    vf = (v != 0);
    cf = (c != 0);
    return {rr, nf, zf, vf, cf};
  endfunction

  // Issues one operation and follows it cycle by cycle to its done pulse.
  // inject: pulse start mid-operation and again during the done cycle.
  task automatic run_op(input logic [3:0] sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit inject);
    logic [W+3:0] exp;
    bit           is_mul;
    int           lat;
    exp    = model(int'(sel), int'(a), int'(b), int'(flag_c));
    is_mul = (sel == 4'd10);
    lat    = is_mul ? W + 1 : 1;
    A = a; B = b; ALU_Sel = sel; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
    chk("busy_after_latch", 32'(busy), 32'(0));
    chk("done_after_latch", 32'(done), 32'(0));
    for (int n = 1; n <= lat; n++) begin
      if (inject && n == 3) begin
        start = 1'b1; ALU_Sel = 4'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (n < lat) begin
        chk("busy_inflight", 32'(busy), 32'(is_mul));
        chk("done_early", 32'(done), 32'(0));
        chk("result_hold_inflight", 32'(Result), 32'(prev_res));
      end else begin
        chk("done_pulse", 32'(done), 32'(1));
        chk("busy_at_done", 32'(busy), 32'(0));
        chk("result", 32'(Result), 32'(exp[W+3:4]));
        chk("nzvc", 32'(NZVC), 32'(exp[3:0]));
      end
    end
    flag_c     = exp[0];
    prev_res   = exp[W+3:4];
    prev_flags = exp[3:0];
    if (inject) begin
      start = 1'b1; ALU_Sel = 4'd0; A = 8'h01; B = 8'h01;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'(0));
    if (inject) begin
      @(posedge clk); #1;
      chk("start_in_done_ignored", 32'(done), 32'(0));
      chk("result_after_ignored", 32'(Result), 32'(prev_res));
    end
  endtask

  initial begin
    total = 0; bad = 0;
    flag_c = 1'b0; prev_res = '0; prev_flags = 4'b0000;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; ALU_Sel = '0;
    #2;
    chk("reset_result", 32'(Result), 32'(0));
    chk("reset_nzvc", 32'(NZVC), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sequence
    run_op(4'd0, 8'h7F, 8'h01, 1'b0);
    chk("add_res", 32'(Result), 32'h80);  chk("add_nzvc", 32'(NZVC), 32'b1010);
    run_op(4'd2, 8'h00, 8'h01, 1'b0);
    chk("sub_res", 32'(Result), 32'hFF);  chk("sub_nzvc", 32'(NZVC), 32'b1001);
    run_op(4'd1, 8'hFF, 8'h01, 1'b0);
    chk("adc1_res", 32'(Result), 32'h01); chk("adc1_nzvc", 32'(NZVC), 32'b0001);
    run_op(4'd1, 8'h00, 8'h00, 1'b0);
    chk("adc2_res", 32'(Result), 32'h01); chk("adc2_nzvc", 32'(NZVC), 32'b0000);
    run_op(4'd10, 8'h10, 8'h10, 1'b1);
    chk("mul1_res", 32'(Result), 32'h00); chk("mul1_nzvc", 32'(NZVC), 32'b0111);
    run_op(4'd10, 8'h0F, 8'h0F, 1'b0);
    chk("mul2_res", 32'(Result), 32'hE1); chk("mul2_nzvc", 32'(NZVC), 32'b1000);
    run_op(4'd9, 8'h01, 8'h00, 1'b0);
    chk("shr_res", 32'(Result), 32'h00);  chk("shr_nzvc", 32'(NZVC), 32'b0101);

    // Reset during multiply iteration 4
    A = 8'hFF; B = 8'hFF; ALU_Sel = 4'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_abort", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_result", 32'(Result), 32'(0));
    chk("abort_nzvc", 32'(NZVC), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'(0));
    end
    rst_n = 1'b1;
    flag_c = 1'b0; prev_res = '0; prev_flags = 4'b0000;
    repeat (W + 2) begin
      @(posedge clk); #1;
      chk("post_abort_no_done", 32'(done), 32'(0));
    end
    run_op(4'd4, 8'hF0, 8'h0F, 1'b0);
    chk("and_res", 32'(Result), 32'h00);  chk("and_nzvc", 32'(NZVC), 32'b0100);

    run_op(4'd13, 8'h55, 8'hAA, 1'b0);
    chk("rsv_res", 32'(Result), 32'h00);  chk("rsv_nzvc", 32'(NZVC), 32'b0100);

    // Idle hold
    repeat (20) begin
      @(posedge clk); #1;
      chk("idle_done", 32'(done), 32'(0));
      chk("idle_result", 32'(Result), 32'(prev_res));
      chk("idle_nzvc", 32'(NZVC), 32'(prev_flags));
    end

    // Randomized operations, including carry chaining and reserved codes
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), (i % 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
